speck_param_core: RTL

Parametrised, iterative SPECK block-cipher core supporting every standard SPECK block/key size, both encryption and decryption. A key is expanded once into an internal round-key store and then reused for any number of blocks. The core sits beneath the cipher control layer and replaces the fixed 128/128, encrypt-only datapath with a valid/ready streaming interface.

---
 rtl/speck_param_core.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/speck_param_core.sv
// Iterative SPECK block-cipher core, any standard block/key size, encrypt
// and decrypt. A key is expanded once into a round-key register file
// (one round key per cycle) and then reused for any number of blocks,
// each taking one round per cycle behind a valid/ready interface.
module speck_param_core #(
  parameter int WORD      = 64,
  parameter int KEY_WORDS = 2,
  parameter int ROUNDS    = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_valid,
  input  logic [KEY_WORDS*WORD-1:0]   key,
  output logic                        key_ready,
  output logic                        keyed,
  input  logic                        in_valid,
  input  logic                        decrypt,
  input  logic [2*WORD-1:0]           data_in,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*WORD-1:0]           data_out,
  output logic [2:0]                  state_response
);

  localparam int ALPHA = (WORD == 16) ? 7 : 8;
  localparam int BETA  = (WORD == 16) ? 2 : 3;
  localparam int IW    = $clog2(ROUNDS);

  localparam logic [IW-1:0] LAST_ROUND = IW'(ROUNDS - 1);
  localparam logic [IW-1:0] LAST_EXP   = IW'(ROUNDS - 2);

  typedef enum logic [2:0] {
    S_NOKEY  = 3'd0,
    S_EXPAND = 3'd1,
    S_IDLE   = 3'd2,
    S_RUN    = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // Round-key store and key-schedule l-words (l[0] is the oldest).
  logic [WORD-1:0] r_rk [ROUNDS];
  logic [WORD-1:0] r_l  [KEY_WORDS-1];

  // Shared counter: key-schedule step in EXPAND, round number in RUN.
  logic [IW-1:0]   r_cnt;
  logic [IW-1:0]   r_idx;
  logic            r_dec;
  logic [WORD-1:0] r_x;
  logic [WORD-1:0] r_y;

  logic              r_keyed;
  logic              r_out_valid;
  logic [2*WORD-1:0] r_data_out;

  logic w_key_ready;
  logic w_in_ready;
  logic w_key_hs;
  logic w_in_hs;
  logic w_out_hs;

  logic [WORD-1:0] w_rk_cur;
  logic [WORD-1:0] w_lnew;
  logic [WORD-1:0] w_rk_next;
  logic [WORD-1:0] w_k;
  logic [WORD-1:0] w_enc_x;
  logic [WORD-1:0] w_enc_y;
  logic [WORD-1:0] w_dec_x;
  logic [WORD-1:0] w_dec_y;
  logic [WORD-1:0] w_nx;
  logic [WORD-1:0] w_ny;

  function automatic logic [WORD-1:0] f_ror(input logic [WORD-1:0] v,
                                            input int unsigned s);
    return (v >> s) | (v << (WORD - s));
  endfunction

  function automatic logic [WORD-1:0] f_rol(input logic [WORD-1:0] v,
                                            input int unsigned s);
    return (v << s) | (v >> (WORD - s));
  endfunction

  assign w_key_hs = key_valid & w_key_ready;
  assign w_in_hs  = in_valid & w_in_ready;
  assign w_out_hs = r_out_valid & out_ready;

  // Key schedule step: derive rk[cnt+1] from rk[cnt] and the oldest l-word.
  assign w_rk_cur  = r_rk[r_cnt];
  assign w_lnew    = (w_rk_cur + f_ror(r_l[0], ALPHA)) ^ {{(WORD-IW){1'b0}}, r_cnt};
  assign w_rk_next = f_rol(w_rk_cur, BETA) ^ w_lnew;

  // One cipher round in either direction, using round key rk[idx].
  assign w_k     = r_rk[r_idx];
  assign w_enc_x = (f_ror(r_x, ALPHA) + r_y) ^ w_k;
  assign w_enc_y = f_rol(r_y, BETA) ^ w_enc_x;
  assign w_dec_y = f_ror(r_x ^ r_y, BETA);
  assign w_dec_x = f_rol((r_x ^ w_k) - w_dec_y, ALPHA);
  assign w_nx    = r_dec ? w_dec_x : w_enc_x;
  assign w_ny    = r_dec ? w_dec_y : w_enc_y;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_NOKEY;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and handshake-ready decode; a key beats a block in IDLE.
  always_comb begin
    w_next      = r_state;
    w_key_ready = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      S_NOKEY: begin
        w_key_ready = 1'b1;
        if (key_valid) w_next = S_EXPAND;
      end
      S_EXPAND: begin
        if (r_cnt == LAST_EXP) w_next = S_IDLE;
      end
      S_IDLE: begin
        w_key_ready = 1'b1;
        w_in_ready  = ~key_valid;
        if (key_valid)     w_next = S_EXPAND;
        else if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (r_cnt == LAST_ROUND) w_next = S_DONE;
      end
      S_DONE: begin
        if (w_out_hs) w_next = S_IDLE;
      end
      default: w_next = S_NOKEY;
    endcase
  end

  // Datapath: key load and expansion, block load and rounds (no reset needed,
  // everything here is loaded on a handshake before it is used).
  always_ff @(posedge clk) begin
    if (w_key_hs) begin
      r_rk[0] <= key[WORD-1:0];
      for (int j = 0; j < KEY_WORDS - 1; j++) begin
        r_l[j] <= key[(j+1)*WORD +: WORD];
      end
      r_cnt <= '0;
    end else if (w_in_hs) begin
      r_x   <= data_in[2*WORD-1:WORD];
      r_y   <= data_in[WORD-1:0];
      r_dec <= decrypt;
      r_idx <= decrypt ? LAST_ROUND : '0;
      r_cnt <= '0;
    end else if (r_state == S_EXPAND) begin
      r_rk[r_cnt + 1'b1] <= w_rk_next;
      for (int j = 0; j < KEY_WORDS - 2; j++) begin
        r_l[j] <= r_l[j+1];
      end
      r_l[KEY_WORDS-2] <= w_lnew;
      r_cnt <= r_cnt + 1'b1;
    end else if (r_state == S_RUN) begin
      r_x   <= w_nx;
      r_y   <= w_ny;
      r_idx <= r_dec ? (r_idx - 1'b1) : (r_idx + 1'b1);
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered status and result: keyed flag, out_valid and data_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_keyed     <= 1'b0;
      r_out_valid <= 1'b0;
      r_data_out  <= '0;
    end else begin
      if (w_key_hs) begin
        r_keyed <= 1'b0;
      end else if (r_state == S_EXPAND && r_cnt == LAST_EXP) begin
        r_keyed <= 1'b1;
      end
      if (r_state == S_RUN && r_cnt == LAST_ROUND) begin
        r_data_out  <= {w_nx, w_ny};
        r_out_valid <= 1'b1;
      end else if (r_state == S_DONE && w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign key_ready      = w_key_ready;
  assign in_ready       = w_in_ready;
  assign keyed          = r_keyed;
  assign out_valid      = r_out_valid;
  assign data_out       = r_data_out;
  assign state_response = r_state;

endmodule
